dat_mem_arb: RTL and testbench
==============================

# dat_mem_arb

Two-port arbiter that shares the single-port `dat_mem` (256×8, combinational read, clocked write) between the processor core and a host/loader port. The core gets fixed priority and a same-cycle grant, so loads and stores stay single-cycle. A starvation counter forces a host slot after a bounded number of lost cycles. It sits between the core's load/store unit, the host/debug loader and the `dat_mem` instance.

## Interface
- `ADDR_W`, 8, address width (256-word memory)
- `DATA_W`, 8, data width
- `STARVE_MAX`, 4, consecutive host-pending cycles lost to the core before the host is forced in (1..15)

- `clk`  in  1  single clock; all state on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `core_req`  in  1  core requests memory this cycle
- `core_we`  in  1  core store (1) / load (0)
- `core_addr`  in  ADDR_W  core address
- `core_wdata`  in  DATA_W  core store data
- `core_gnt`  out  1  core owns memory this cycle (combinational); core stalls when 0
- `core_rdata`  out  DATA_W  `mem_dat_out` passthrough, valid when `core_gnt & ~core_we`
- `host_valid`  in  1  host request pending
- `host_we`  in  1  host write (1) / read (0)
- `host_addr`  in  ADDR_W  host address
- `host_wdata`  in  DATA_W  host write data
- `host_ready`  out  1  host request accepted this cycle (combinational)
- `host_rvalid`  out  1  registered read data valid, one-cycle pulse
- `host_rdata`  out  DATA_W  registered read data
- `mem_wr_en`  out  1  to `dat_mem.wr_en`
- `mem_addr`  out  ADDR_W  to `dat_mem.addr`
- `mem_dat_in`  out  DATA_W  to `dat_mem.dat_in`
- `mem_dat_out`  in  DATA_W  from `dat_mem.dat_out`

## Operation
- States: `NORMAL`, `FORCE_HOST`. Reset → `NORMAL`, `starve_cnt`=0.
- `NORMAL`: `core_gnt = core_req`; `host_ready = host_valid & ~core_req`.
- `FORCE_HOST`: `host_ready = host_valid`; `core_gnt = core_req & ~host_valid`.
- Exactly one owner per cycle. The mux drives `mem_addr`, `mem_dat_in` and `mem_wr_en = owner_we` from the owner. With no owner: `mem_wr_en`=0 and `mem_addr` = `core_addr`.
- `starve_cnt` (4 bits):
  - Increments when `host_valid & ~host_ready`.
  - Clears on `host_ready`.
  - Saturates at `STARVE_MAX`.
- Transitions:
  - `NORMAL`→`FORCE_HOST` when the next `starve_cnt` == `STARVE_MAX`.
  - `FORCE_HOST`→`NORMAL` after one host handshake (`host_valid & host_ready`) or when `host_valid` drops.
- Host protocol: `host_valid` and its payload are held stable until `host_ready`. A violation is a bench assertion failure; the RTL does not check it.
- Host read: `host_rdata <= mem_dat_out` and `host_rvalid <= 1` on the accept edge. `host_rvalid` is 0 otherwise.
- Host write completes at the accept edge; no response pulse.
- Same address, both requesters, same cycle: only the owner's access occurs. The loser retries, so a host read always sees the data written by any earlier-granted core store.

## Timing
- Reset values:
  - `host_rvalid`=0, `host_rdata`=0, state `NORMAL`, `starve_cnt`=0.
  - While `rst_n`=0, `core_gnt`, `host_ready` and `mem_wr_en` are forced 0.
- Core latency: 0 cycles (grant and read data in the request cycle); store written at that cycle's edge.
- Host read latency: data at `host_rvalid`, one cycle after the `host_ready` cycle.
- Worst-case host wait: `STARVE_MAX`+1 cycles after `host_valid` rises.
- Worst-case core stall: 1 cycle per forced host slot.
- Reset asserted mid-operation: state, counter and `host_rvalid` clear immediately. A pending host transaction is dropped and the host re-issues it.

## Structure
- Shared package `dat_mem_pkg`:
  - `ADDR_W` and `DATA_W` localparams.
  - `arb_state_t` enum {`NORMAL`, `FORCE_HOST`}.
  - `MEM_DEPTH`=256.
- No sub-module. The counter, FSM and mux are inline (~150 lines). `dat_mem` is instantiated alongside, in the parent.

## Test plan
- Reset: `rst_n`=0 with `core_req`=1 and `host_valid`=1 → `core_gnt`=0, `host_ready`=0, `mem_wr_en`=0, `host_rvalid`=0.
- Core only, store 0x5A to 0x10, then load 0x10 → `core_gnt`=1 both cycles; load returns `core_rdata`=0x5A.
- Host only, write 0x3C to 0x20, then read 0x20 → `host_ready` in the request cycle; `host_rvalid`=1 with `host_rdata`=0x3C on the next cycle.
- Starvation: `core_req` held 1, host read of 0x3C pending → `host_ready`=0 for exactly 4 cycles, then `host_ready`=1 with `core_gnt`=0. `starve_cnt` returns to 0 and the core is granted the following cycle.
- Same-address collision: core store 0xFF and host write 0x11 to 0x40 in the same cycle → core wins. Host write lands on a later cycle; a final host read returns 0x11.
- Reset mid-transaction: host read in `FORCE_HOST`, `rst_n` pulsed low → `host_rvalid` stays 0, state is `NORMAL`, and the re-issued read returns the correct data.

Source files
------------

// File: rtl/dat_mem_pkg.sv
// Shared types and sizes for the data-memory arbiter and the dat_mem it fronts.
package dat_mem_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 256;
  localparam int CNT_W     = 4;

  typedef enum logic {
    NORMAL     = 1'b0,
    FORCE_HOST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dat_mem_arb_if.sv
// Core, host and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface dat_mem_arb_if;
  import dat_mem_pkg::*;

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic [DATA_W-1:0] core_rdata;

  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dat_in;
  logic [DATA_W-1:0] mem_dat_out;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rdata,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata,
    output mem_wr_en, mem_addr, mem_dat_in,
    input  mem_dat_out
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rdata,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata,
    input  mem_wr_en, mem_addr, mem_dat_in,
    output mem_dat_out
  );

endinterface

// File: rtl/dat_mem_arb.sv
// Fixed-priority arbiter sharing dat_mem between the core (same-cycle grant)
// and the host loader, with a starvation counter that forces a host slot.
//
// state      | meaning
// -----------+---------------------------------------------------------
// NORMAL     | core has priority; host only gets idle core cycles
// FORCE_HOST | host starved STARVE_MAX cycles; host owns the next slot
module dat_mem_arb
  import dat_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dat_mem_arb_if.slave  bus
);

  localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic              core_gnt;
  logic              host_ready;

  // Grants are held low during reset so nothing reaches the memory.
  always_comb begin
    core_gnt   = 1'b0;
    host_ready = 1'b0;
    if (rst_n) begin
      if (state_q == FORCE_HOST) begin
        host_ready = bus.host_valid;
        core_gnt   = bus.core_req & ~bus.host_valid;
      end else begin
        core_gnt   = bus.core_req;
        host_ready = bus.host_valid & ~bus.core_req;
      end
    end
  end

  always_comb begin
    bus.mem_addr   = bus.core_addr;
    bus.mem_dat_in = bus.core_wdata;
    bus.mem_wr_en  = 1'b0;
    if (core_gnt) begin
      bus.mem_wr_en  = bus.core_we;
    end else if (host_ready) begin
      bus.mem_addr   = bus.host_addr;
      bus.mem_dat_in = bus.host_wdata;
      bus.mem_wr_en  = bus.host_we;
    end
  end

  always_comb begin
    starve_cnt_d  = starve_cnt_q;
    state_d       = state_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;

    if (host_ready) begin
      starve_cnt_d = '0;
    end else if (bus.host_valid) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_MAX_C) ? STARVE_MAX_C
                                                    : starve_cnt_q + 1'b1;
    end

    if (host_ready && !bus.host_we) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = bus.mem_dat_out;
    end

    case (state_q)
      NORMAL: begin
        if (starve_cnt_d == STARVE_MAX_C) state_d = FORCE_HOST;
      end
      FORCE_HOST: begin
        if (host_ready || !bus.host_valid) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= NORMAL;
      starve_cnt_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.core_rdata  = bus.mem_dat_out;
  assign bus.host_ready  = host_ready;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dat_mem_arb.sv
// Scoreboard bench for dat_mem_arb: directed vectors push expected read data,
// a negedge monitor pops and compares whenever a read result is presented.
module tb_dat_mem_arb;
  import dat_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dat_mem_arb_if bus();

  dat_mem_arb #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  assign bus.mem_dat_out = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_dat_in;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] host_q[$];
  logic [7:0] core_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [7:0] caddr,
                       input logic [7:0] cwd, input logic hv, input logic hwe,
                       input logic [7:0] haddr, input logic [7:0] hwd);
    bus.core_req   = creq;
    bus.core_we    = cwe;
    bus.core_addr  = caddr;
    bus.core_wdata = cwd;
    bus.host_valid = hv;
    bus.host_we    = hwe;
    bus.host_addr  = haddr;
    bus.host_wdata = hwd;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares read results against queued expectations.
  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.host_rvalid) begin
      if (host_q.size() == 0) chk("host_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = host_q.pop_front();
        chk("host_rdata", 32'(bus.host_rdata), 32'(e));
      end
    end
    if (rst_n && bus.core_req && bus.core_gnt && !bus.core_we) begin
      if (core_q.size() == 0) chk("core_load_unexpected", 32'd1, 32'd0);
      else begin
        e = core_q.pop_front();
        chk("core_rdata", 32'(bus.core_rdata), 32'(e));
      end
    end
  end

  // Host payload must stay stable while pending.
  logic       h_pend = 1'b0;
  logic       h_we_p;
  logic [7:0] h_addr_p, h_wd_p;
  always @(posedge clk) begin
    if (rst_n && h_pend)
      assert (bus.host_valid && bus.host_we == h_we_p && bus.host_addr == h_addr_p
              && bus.host_wdata == h_wd_p)
        else $error("host protocol violated while request pending");
    h_pend   <= bus.host_valid & ~bus.host_ready & rst_n;
    h_we_p   <= bus.host_we;
    h_addr_p <= bus.host_addr;
    h_wd_p   <= bus.host_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    drive(1, 1, 8'h10, 8'hAA, 1, 1, 8'h10, 8'hBB);

    // Reset holds everything off
    @(negedge clk);
    chk("rst_core_gnt",    32'(bus.core_gnt),    32'd0);
    chk("rst_host_ready",  32'(bus.host_ready),  32'd0);
    chk("rst_mem_wr_en",   32'(bus.mem_wr_en),   32'd0);
    chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Core store then load
    next();
    drive(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("core_st_gnt", 32'(bus.core_gnt), 32'd1);
    next();
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    core_q.push_back(8'h5A);
    @(negedge clk);
    chk("core_ld_gnt", 32'(bus.core_gnt), 32'd1);

    // Host write then read
    next();
    drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C);
    @(negedge clk);
    chk("host_wr_ready", 32'(bus.host_ready), 32'd1);
    next();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
    host_q.push_back(8'h3C);
    @(negedge clk);
    chk("host_rd_ready", 32'(bus.host_ready), 32'd1);
    chk("host_wr_no_rvalid", 32'(bus.host_rvalid), 32'd0);
    next();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

    // Starvation: core busy, host read pending
    next();
    drive(1, 1, 8'h80, 8'h00, 1, 0, 8'h20, 8'h00);
    host_q.push_back(8'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("starve_ready_lo", 32'(bus.host_ready), 32'd0);
      chk("starve_core_gnt", 32'(bus.core_gnt),   32'd1);
      next();
    end
    @(negedge clk);
    chk("force_ready",    32'(bus.host_ready), 32'd1);
    chk("force_core_gnt", 32'(bus.core_gnt),   32'd0);
    next();
    drive(1, 1, 8'h80, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("after_force_gnt", 32'(bus.core_gnt), 32'd1);
    chk("after_force_cnt", 32'(dut.starve_cnt_q), 32'd0);
    chk("after_force_state", 32'(dut.state_q), 32'(NORMAL));

    // Same-address collision: core store wins, host write retries
    next();
    drive(1, 1, 8'h40, 8'hFF, 1, 1, 8'h40, 8'h11);
    @(negedge clk);
    chk("coll_core_gnt",   32'(bus.core_gnt),   32'd1);
    chk("coll_host_ready", 32'(bus.host_ready), 32'd0);
    next();
    drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h11);
    @(negedge clk);
    chk("coll_retry_ready", 32'(bus.host_ready), 32'd1);
    next();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00);
    host_q.push_back(8'h11);
    next();
    drive(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
    core_q.push_back(8'h11);
    next();

    // Reset while host is being forced in
    drive(1, 1, 8'h80, 8'h00, 1, 0, 8'h40, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_wait", 32'(bus.host_ready), 32'd0);
      next();
    end
    @(negedge clk);
    chk("rst_mid_force", 32'(dut.state_q), 32'(FORCE_HOST));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus.host_ready), 32'd0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(NORMAL));
    chk("rst_mid_cnt",   32'(dut.starve_cnt_q), 32'd0);
    next();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst_mid_rvalid", 32'(bus.host_rvalid), 32'd0);
    rst_n = 1'b1;
    next();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00);
    host_q.push_back(8'h11);
    @(negedge clk);
    chk("reissue_ready", 32'(bus.host_ready), 32'd1);
    next();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    next();
    next();

    chk("host_q_drained", 32'(host_q.size()), 32'd0);
    chk("core_q_drained", 32'(core_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
